// File: rtl/sampler_pkg.sv
// sampler_pkg: shared FSM states and LFSR constants for the sample sequencer.
package sampler_pkg;
   typedef enum logic [2:0] {IDLE, TRY, HOLD, DONE, FAIL} state_t;
   localparam logic [31:0] LFSR_TAPS = 32'h80200003;
   localparam logic [31:0] LFSR_ONE  = 32'h1;
endpackage

// File: rtl/sample_sequencer_if.sv
// sample_sequencer_if: accepted-sample valid/ready handshake.
interface sample_sequencer_if #(parameter int DW = 32);
   logic          smp_valid;
   logic [DW-1:0] smp_data;
   logic          smp_ready;
   modport master (output smp_valid, smp_data, input smp_ready);
   modport slave  (input smp_valid, smp_data, output smp_ready);
endinterface

// File: rtl/sampler_lfsr.sv
// sampler_lfsr: right-shift Galois LFSR with seed load; a zero seed is replaced by 1.
module sampler_lfsr
   import sampler_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [DW-1:0] seed,
   input  logic          step,
   output logic [DW-1:0] value
);
   always_ff @(posedge clk or posedge rst)
      if (rst) value <= DW'(LFSR_ONE);
      else if (load) value <= (seed == '0) ? DW'(LFSR_ONE) : seed;
      else if (step) value <= (value >> 1) ^ (value[0] ? DW'(LFSR_TAPS) : '0);
endmodule

// File: rtl/sample_sequencer.sv
// sample_sequencer: walks an LFSR, emits candidates the external checker accepts,
// and stops after num_samples hits or max_attempts misses for one sample.
module sample_sequencer
   import sampler_pkg::*;
#(
   parameter int DW = 32,
   parameter int CW = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [DW-1:0]       seed,
   input  logic [CW-1:0]       num_samples,
   input  logic [CW-1:0]       max_attempts,
   output logic [DW-1:0]       cand,
   input  logic                sat,
   sample_sequencer_if.master  smp,
   output logic                busy,
   output logic                done,
   output logic                fail,
   output logic [CW-1:0]       attempts
);
   state_t        state;
   logic [CW-1:0] count, num_q, max_q;
   logic          idle_like, load, step, hit;
   logic [CW-1:0] att_inc;

   assign idle_like = (state == IDLE) || (state == DONE) || (state == FAIL);
   assign load      = start && idle_like;
   assign step      = ((state == TRY) && !sat) || ((state == HOLD) && smp.smp_ready);
   assign att_inc   = (&attempts) ? attempts : attempts + CW'(1);
   assign hit       = (max_q != '0) && (attempts + CW'(1) == max_q);

   sampler_lfsr #(.DW(DW)) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .seed  (seed),
      .step  (step),
      .value (cand)
   );

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state         <= IDLE;
         smp.smp_valid <= 1'b0;
         smp.smp_data  <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         fail          <= 1'b0;
         attempts      <= '0;
         count         <= '0;
         num_q         <= '0;
         max_q         <= '0;
      end else begin
         case (state)
            IDLE, DONE, FAIL:
               if (start) begin
                  num_q    <= num_samples;
                  max_q    <= max_attempts;
                  count    <= '0;
                  attempts <= '0;
                  fail     <= 1'b0;
                  done     <= (num_samples == '0);
                  busy     <= (num_samples != '0);
                  state    <= (num_samples == '0) ? DONE : TRY;
               end
            TRY:
               if (sat) begin
                  smp.smp_data  <= cand;
                  smp.smp_valid <= 1'b1;
                  state         <= HOLD;
               end else begin
                  attempts <= att_inc;
                  if (hit) begin
                     state <= FAIL;
                     fail  <= 1'b1;
                     busy  <= 1'b0;
                  end
               end
            HOLD:
               if (smp.smp_ready) begin
                  smp.smp_valid <= 1'b0;
                  count         <= count + CW'(1);
                  attempts      <= '0;
                  if (count + CW'(1) == num_q) begin
                     state <= DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else state <= TRY;
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_sample_sequencer.sv
// tb_sample_sequencer: directed runs with a queue scoreboard checked by a handshake monitor.
module tb_sample_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        sat = 1'b0;
   logic [31:0] seed = '0;
   logic [15:0] num_samples = '0;
   logic [15:0] max_attempts = '0;
   logic [31:0] cand;
   logic        busy, done, fail;
   logic [15:0] attempts;
   logic [31:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          xfers = 0;

   sample_sequencer_if #(.DW(32)) sif ();

   sample_sequencer #(.DW(32), .CW(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .seed         (seed),
      .num_samples  (num_samples),
      .max_attempts (max_attempts),
      .cand         (cand),
      .sat          (sat),
      .smp          (sif.master),
      .busy         (busy),
      .done         (done),
      .fail         (fail),
      .attempts     (attempts)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (!rst && sif.smp_valid && sif.smp_ready) begin
         logic [31:0] e;
         xfers++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_sample got %h expected none", sif.smp_data);
         end else begin
            e = exp_q.pop_front();
            if (sif.smp_data !== e) begin
               errors++;
               $display("FAIL smp_data got %h expected %h", sif.smp_data, e);
            end
         end
      end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic go(input logic [31:0] s, input logic [15:0] n, input logic [15:0] m);
      seed = s;
      num_samples = n;
      max_attempts = m;
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
   endtask

   task automatic wait_end(input int budget, output int busy_cycles);
      int n = 0;
      busy_cycles = 0;
      while (!(done || fail) && n < budget) begin
         @(negedge clk);
         if (busy) busy_cycles++;
         n++;
      end
      if (!(done || fail)) begin
         checks++;
         errors++;
         $display("FAIL timeout waiting for done/fail after %0d cycles", n);
      end
   endtask

   task automatic wait_valid(input int budget);
      int n = 0;
      while (!sif.smp_valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!sif.smp_valid) begin
         checks++;
         errors++;
         $display("FAIL timeout waiting for smp_valid after %0d cycles", n);
      end
   endtask

   task automatic run_three;
      int bc;
      exp_q.push_back(32'h00000001);
      exp_q.push_back(32'h80200003);
      exp_q.push_back(32'hC0300002);
      go(32'h1, 16'd3, 16'd0);
      wait_end(50, bc);
      chk("three_done", done, 1);
      chk("three_fail", fail, 0);
      chk("three_busy_cycles", bc, 6);
      chk("three_queue_empty", exp_q.size(), 0);
   endtask

   initial begin
      int bc, x0;
      logic saw;
      sif.smp_ready = 1'b1;
      #1;
      chk("async_reset_valid", sif.smp_valid, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_valid", sif.smp_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_fail", fail, 0);
      chk("reset_attempts", attempts, 0);
      chk("reset_cand", cand, 32'h1);
      chk("reset_data", sif.smp_data, 0);
      @(posedge clk); #2;
      rst = 1'b0;
      // three samples, checker always satisfied, consumer always ready
      sat = 1'b1;
      run_three();
      // zero seed is replaced by 1
      exp_q.push_back(32'h00000001);
      go(32'h0, 16'd1, 16'd0);
      wait_end(20, bc);
      chk("seed0_done", done, 1);
      chk("seed0_queue_empty", exp_q.size(), 0);
      // checker never satisfied: fail after exactly five tries
      sat = 1'b0;
      x0 = xfers;
      go(32'h1, 16'd2, 16'd5);
      wait_end(30, bc);
      chk("limit_fail", fail, 1);
      chk("limit_done", done, 0);
      chk("limit_attempts", attempts, 5);
      chk("limit_try_cycles", bc, 5);
      chk("limit_no_sample", xfers - x0, 0);
      repeat (3) @(negedge clk);
      chk("fail_held", fail, 1);
      chk("attempts_held", attempts, 5);
      // back-pressure: data held for ten stalled cycles, start ignored while busy
      sat = 1'b1;
      sif.smp_ready = 1'b0;
      x0 = xfers;
      go(32'h1, 16'd1, 16'd0);
      wait_valid(20);
      saw = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            seed = 32'h5;
            start = 1'b1;
         end
         if (i == 4) start = 1'b0;
         @(negedge clk);
         if (sif.smp_valid !== 1'b1 || sif.smp_data !== 32'h1 || cand !== 32'h1) saw = 1'b1;
      end
      chk("stall_stable", saw, 0);
      chk("stall_busy", busy, 1);
      exp_q.push_back(32'h00000001);
      @(posedge clk); #2;
      sif.smp_ready = 1'b1;
      wait_end(20, bc);
      chk("stall_done", done, 1);
      chk("stall_one_xfer", xfers - x0, 1);
      // reset in the middle of HOLD
      sif.smp_ready = 1'b0;
      go(32'h1, 16'd3, 16'd0);
      wait_valid(20);
      #2;
      rst = 1'b1;
      #1;
      chk("midhold_valid", sif.smp_valid, 0);
      chk("midhold_busy", busy, 0);
      chk("midhold_done", done, 0);
      chk("midhold_cand", cand, 32'h1);
      chk("midhold_attempts", attempts, 0);
      @(posedge clk); #2;
      rst = 1'b0;
      saw = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (sif.smp_valid || busy) saw = 1'b1;
      end
      chk("post_reset_quiet", saw, 0);
      sif.smp_ready = 1'b1;
      run_three();
      // zero samples: done the cycle after start, never busy
      go(32'h1, 16'd0, 16'd0);
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      saw = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (busy || sif.smp_valid) saw = 1'b1;
      end
      chk("zero_quiet", saw, 0);
      chk("final_queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
